// File: rtl/violation_ctrl.sv
// -----------------------------------------------------------------------------
// violation_ctrl
//
// Classifies raw violation inputs (bandpass[3:0], drift[8:4], delta
// mismatch[10:9] in the default 11-bit build) into sticky warning/error
// status, tracks the recovery lock state, and offers a read-and-clear
// snapshot port.
//
// Ports
//   sys_dom_i          clock + synchronous active-high reset bundle
//   clear_state_i      soft clear, same effect as reset
//   violations_i       raw violation bits
//   locked_i           recovery fully-locked-in status
//   holdoff_cycles_i   cycles to wait after lock before qualifying
//   cfg_wr_en_i/idx/class   per-violation class write
//                      (0 IGNORE, 1 WARNING, 2 ERROR, 3 ERROR_POST_LOCK)
//   rd_req_i           read-and-clear request
//   rd_valid_o         one-cycle strobe, cycle after rd_req_i
//   rd_error_o/rd_warning_o/rd_lock_lost_o  snapshot, held between reads
//   error_irq_o        OR of error status and lock_lost (registered)
//   warning_irq_o      OR of warning status (registered)
//   qualified_o        locked and holdoff expired
//
// Optional feature, macro VIOLATION_CTRL_FIRST_CAPTURE_EN:
//   first_idx_o/first_valid_o/first_time_o report the lowest-index error
//   among the first error events since the last read, with the value of a
//   free-running wrapping cycle counter. Returned with the read snapshot.
// -----------------------------------------------------------------------------

package common_p;
  typedef struct packed {
    logic clk;
    logic srst;
  } clk_dom_s;
endpackage

package clks_alot_p;
  localparam int RATE_COUNTER_WIDTH = 16;
endpackage

module violation_ctrl #(
  parameter int NUM_VIOLATIONS = 11,
  parameter int HOLDOFF_WIDTH  = clks_alot_p::RATE_COUNTER_WIDTH,
  localparam int IDX_W = (NUM_VIOLATIONS > 1) ? $clog2(NUM_VIOLATIONS) : 1
) (
  input  common_p::clk_dom_s         sys_dom_i,
  input  logic                       clear_state_i,
  input  logic [NUM_VIOLATIONS-1:0]  violations_i,
  input  logic                       locked_i,
  input  logic [HOLDOFF_WIDTH-1:0]   holdoff_cycles_i,
  input  logic                       cfg_wr_en_i,
  input  logic [IDX_W-1:0]           cfg_wr_idx_i,
  input  logic [1:0]                 cfg_wr_class_i,
  input  logic                       rd_req_i,
  output logic                       rd_valid_o,
  output logic [NUM_VIOLATIONS-1:0]  rd_error_o,
  output logic [NUM_VIOLATIONS-1:0]  rd_warning_o,
  output logic                       rd_lock_lost_o,
  output logic                       error_irq_o,
  output logic                       warning_irq_o,
  output logic                       qualified_o
`ifdef VIOLATION_CTRL_FIRST_CAPTURE_EN
  ,
  output logic [IDX_W-1:0]           first_idx_o,
  output logic                       first_valid_o,
  output logic [31:0]                first_time_o
`endif
);

  localparam logic [1:0] CLASS_IGNORE          = 2'd0;
  localparam logic [1:0] CLASS_WARNING         = 2'd1;
  localparam logic [1:0] CLASS_ERROR           = 2'd2;
  localparam logic [1:0] CLASS_ERROR_POST_LOCK = 2'd3;

  localparam logic [1:0] ST_UNLOCKED  = 2'd0;
  localparam logic [1:0] ST_HOLDOFF   = 2'd1;
  localparam logic [1:0] ST_QUALIFIED = 2'd2;

  logic clk;
  logic srst;
  logic clr;

  assign clk  = sys_dom_i.clk;
  assign srst = sys_dom_i.srst;
  // Soft clear and reset share every register's clear path.
  assign clr  = srst | clear_state_i;

  // ---------------------------------------------------------------------------
  // Lock FSM
  // ---------------------------------------------------------------------------
  logic [1:0]               state_reg, state_next;
  logic [HOLDOFF_WIDTH-1:0] holdoff_reg, holdoff_next;

  always_comb begin
    state_next   = state_reg;
    holdoff_next = holdoff_reg;
    if (!locked_i) begin
      state_next   = ST_UNLOCKED;
      holdoff_next = '0;
    end else begin
      case (state_reg)
        ST_UNLOCKED: begin
          // A zero holdoff skips the countdown entirely.
          state_next   = (holdoff_cycles_i == '0) ? ST_QUALIFIED : ST_HOLDOFF;
          holdoff_next = holdoff_cycles_i;
        end
        ST_HOLDOFF: begin
          // Count reaches zero on the same edge the state qualifies.
          if (holdoff_reg <= HOLDOFF_WIDTH'(1)) begin
            state_next   = ST_QUALIFIED;
            holdoff_next = '0;
          end else begin
            holdoff_next = holdoff_reg - HOLDOFF_WIDTH'(1);
          end
        end
        ST_QUALIFIED: state_next = ST_QUALIFIED;
        default:      state_next = ST_UNLOCKED;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_reg   <= ST_UNLOCKED;
      holdoff_reg <= '0;
    end else begin
      state_reg   <= state_next;
      holdoff_reg <= holdoff_next;
    end
  end

  assign qualified_o = (state_reg == ST_QUALIFIED);

  // Only losing a qualified lock counts; aborting a holdoff does not.
  logic lock_lost_ev;
  assign lock_lost_ev = (state_reg == ST_QUALIFIED) && !locked_i;

  // ---------------------------------------------------------------------------
  // Per-violation class registers and event decode
  // ---------------------------------------------------------------------------
  logic [NUM_VIOLATIONS-1:0] error_ev;
  logic [NUM_VIOLATIONS-1:0] warning_ev;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_VIOLATIONS; gi++) begin : g_viol
      logic [1:0] class_reg;

      // Indices beyond NUM_VIOLATIONS match no slot, so those writes vanish.
      always_ff @(posedge clk) begin
        if (clr)
          class_reg <= CLASS_ERROR_POST_LOCK;
        else if (cfg_wr_en_i && (cfg_wr_idx_i == IDX_W'(gi)))
          class_reg <= cfg_wr_class_i;
      end

      assign error_ev[gi] = violations_i[gi] &&
                            ((class_reg == CLASS_ERROR) ||
                             ((class_reg == CLASS_ERROR_POST_LOCK) && qualified_o));
      assign warning_ev[gi] = violations_i[gi] && (class_reg == CLASS_WARNING);
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Sticky status, read-and-clear, interrupts
  // ---------------------------------------------------------------------------
  logic [NUM_VIOLATIONS-1:0] error_status_reg, error_status_next, error_snap;
  logic [NUM_VIOLATIONS-1:0] warning_status_reg, warning_status_next, warning_snap;
  logic                      lock_lost_reg, lock_lost_next, lock_lost_snap;
  logic                      rd_valid_reg;
  logic [NUM_VIOLATIONS-1:0] rd_error_reg, rd_warning_reg;
  logic                      rd_lock_lost_reg;
  logic                      error_irq_reg, warning_irq_reg;

  // Events of the request cycle go into the snapshot, not into the status,
  // so they are reported exactly once.
  always_comb begin
    error_snap          = error_status_reg | error_ev;
    warning_snap        = warning_status_reg | warning_ev;
    lock_lost_snap      = lock_lost_reg | lock_lost_ev;
    error_status_next   = rd_req_i ? '0 : error_snap;
    warning_status_next = rd_req_i ? '0 : warning_snap;
    lock_lost_next      = rd_req_i ? 1'b0 : lock_lost_snap;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      error_status_reg   <= '0;
      warning_status_reg <= '0;
      lock_lost_reg      <= 1'b0;
      rd_valid_reg       <= 1'b0;
      rd_error_reg       <= '0;
      rd_warning_reg     <= '0;
      rd_lock_lost_reg   <= 1'b0;
      error_irq_reg      <= 1'b0;
      warning_irq_reg    <= 1'b0;
    end else begin
      error_status_reg   <= error_status_next;
      warning_status_reg <= warning_status_next;
      lock_lost_reg      <= lock_lost_next;
      rd_valid_reg       <= rd_req_i;
      if (rd_req_i) begin
        rd_error_reg     <= error_snap;
        rd_warning_reg   <= warning_snap;
        rd_lock_lost_reg <= lock_lost_snap;
      end
      // Irqs follow the status being written, so they track it cycle-exact.
      error_irq_reg   <= (|error_status_next) | lock_lost_next;
      warning_irq_reg <= |warning_status_next;
    end
  end

  assign rd_valid_o     = rd_valid_reg;
  assign rd_error_o     = rd_error_reg;
  assign rd_warning_o   = rd_warning_reg;
  assign rd_lock_lost_o = rd_lock_lost_reg;
  assign error_irq_o    = error_irq_reg;
  assign warning_irq_o  = warning_irq_reg;

  // ---------------------------------------------------------------------------
  // First-error capture
  // ---------------------------------------------------------------------------
`ifdef VIOLATION_CTRL_FIRST_CAPTURE_EN
  logic [31:0]      cycle_cnt_reg;
  logic             hit_valid_reg, hit_valid_now;
  logic [IDX_W-1:0] hit_idx_reg, hit_idx_now;
  logic [31:0]      hit_time_reg, hit_time_now;
  logic [IDX_W-1:0] lowest_err_idx;
  logic             first_valid_reg;
  logic [IDX_W-1:0] first_idx_reg;
  logic [31:0]      first_time_reg;

  // Priority encoder: scanning downward leaves the lowest set index.
  always_comb begin
    lowest_err_idx = '0;
    for (int i = NUM_VIOLATIONS - 1; i >= 0; i--) begin
      if (error_ev[i]) lowest_err_idx = IDX_W'(i);
    end
  end

  // Once captured, later errors leave the record untouched until a read.
  always_comb begin
    hit_valid_now = hit_valid_reg | (|error_ev);
    hit_idx_now   = hit_valid_reg ? hit_idx_reg  : lowest_err_idx;
    hit_time_now  = hit_valid_reg ? hit_time_reg : cycle_cnt_reg;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      cycle_cnt_reg   <= '0;
      hit_valid_reg   <= 1'b0;
      hit_idx_reg     <= '0;
      hit_time_reg    <= '0;
      first_valid_reg <= 1'b0;
      first_idx_reg   <= '0;
      first_time_reg  <= '0;
    end else begin
      cycle_cnt_reg <= cycle_cnt_reg + 32'd1;
      if (rd_req_i) begin
        first_valid_reg <= hit_valid_now;
        first_idx_reg   <= hit_valid_now ? hit_idx_now  : '0;
        first_time_reg  <= hit_valid_now ? hit_time_now : '0;
        hit_valid_reg   <= 1'b0;
        hit_idx_reg     <= '0;
        hit_time_reg    <= '0;
      end else begin
        hit_valid_reg <= hit_valid_now;
        hit_idx_reg   <= hit_idx_now;
        hit_time_reg  <= hit_time_now;
      end
    end
  end

  assign first_valid_o = first_valid_reg;
  assign first_idx_o   = first_idx_reg;
  assign first_time_o  = first_time_reg;
`else
  // Capture disabled: no first-error registers or ports are built.
`endif

endmodule

// File: tb/tb_violation_ctrl.sv
`timescale 1ns/1ps
module tb_violation_ctrl;

  localparam int NV = 11;
  localparam int HW = clks_alot_p::RATE_COUNTER_WIDTH;
  localparam int IW = $clog2(NV);

  logic                clk = 1'b0;
  logic                srst = 1'b1;
  common_p::clk_dom_s  sys_dom;
  logic                clear_state = 1'b0;
  logic [NV-1:0]       violations = '0;
  logic                locked = 1'b0;
  logic [HW-1:0]       holdoff = '0;
  logic                cfg_wr_en = 1'b0;
  logic [IW-1:0]       cfg_wr_idx = '0;
  logic [1:0]          cfg_wr_class = '0;
  logic                rd_req = 1'b0;
  logic                rd_valid;
  logic [NV-1:0]       rd_error;
  logic [NV-1:0]       rd_warning;
  logic                rd_lock_lost;
  logic                error_irq;
  logic                warning_irq;
  logic                qualified;
`ifdef VIOLATION_CTRL_FIRST_CAPTURE_EN
  logic [IW-1:0]       first_idx;
  logic                first_valid;
  logic [31:0]         first_time;
`endif

  assign sys_dom.clk  = clk;
  assign sys_dom.srst = srst;

  always #5 clk = ~clk;

  violation_ctrl #(.NUM_VIOLATIONS(NV), .HOLDOFF_WIDTH(HW)) dut (
    .sys_dom_i        (sys_dom),
    .clear_state_i    (clear_state),
    .violations_i     (violations),
    .locked_i         (locked),
    .holdoff_cycles_i (holdoff),
    .cfg_wr_en_i      (cfg_wr_en),
    .cfg_wr_idx_i     (cfg_wr_idx),
    .cfg_wr_class_i   (cfg_wr_class),
    .rd_req_i         (rd_req),
    .rd_valid_o       (rd_valid),
    .rd_error_o       (rd_error),
    .rd_warning_o     (rd_warning),
    .rd_lock_lost_o   (rd_lock_lost),
    .error_irq_o      (error_irq),
    .warning_irq_o    (warning_irq),
    .qualified_o      (qualified)
`ifdef VIOLATION_CTRL_FIRST_CAPTURE_EN
    ,
    .first_idx_o      (first_idx),
    .first_valid_o    (first_valid),
    .first_time_o     (first_time)
`endif
  );

  typedef struct packed {
    logic [NV-1:0] err;
    logic [NV-1:0] warn;
    logic          lost;
  } rd_exp_t;

  rd_exp_t exp_q[$];
  rd_exp_t mon_e;
  int      errors = 0;
  int      checks = 0;
  int      reads_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  // Scoreboard monitor: every rd_valid strobe consumes one expected snapshot.
  always @(negedge clk) begin
    if (rd_valid === 1'b1) begin
      reads_seen++;
      if (exp_q.size() == 0) begin
        check("unexpected_rd_valid", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        $display("read #%0d: err=0x%0h warn=0x%0h lost=%0b", reads_seen, rd_error, rd_warning, rd_lock_lost);
        check($sformatf("rd%0d_error", reads_seen), 32'(rd_error), 32'(mon_e.err));
        check($sformatf("rd%0d_warning", reads_seen), 32'(rd_warning), 32'(mon_e.warn));
        check($sformatf("rd%0d_lock_lost", reads_seen), 32'(rd_lock_lost), 32'(mon_e.lost));
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic cfg_write(input logic [IW-1:0] idx, input logic [1:0] cls);
    cfg_wr_en = 1'b1; cfg_wr_idx = idx; cfg_wr_class = cls;
    tick();
    cfg_wr_en = 1'b0;
  endtask

  task automatic pulse(input logic [NV-1:0] v);
    violations = v;
    tick();
    violations = '0;
  endtask

  task automatic push_exp(input logic [NV-1:0] e, input logic [NV-1:0] w, input logic l);
    rd_exp_t t;
    t.err = e; t.warn = w; t.lost = l;
    exp_q.push_back(t);
  endtask

  // Request in this cycle; strobe is checked by the monitor one cycle later.
  task automatic do_read(input logic [NV-1:0] e, input logic [NV-1:0] w, input logic l);
    rd_req = 1'b1;
    push_exp(e, w, l);
    tick();
    rd_req = 1'b0;
    tick();
  endtask

  initial begin
    repeat (3) tick();
    srst = 1'b0;
    tick();

    // Reset state
    check("reset_rd_valid", 32'(rd_valid), 32'd0);
    check("reset_error_irq", 32'(error_irq), 32'd0);
    check("reset_warning_irq", 32'(warning_irq), 32'd0);
    check("reset_qualified", 32'(qualified), 32'd0);
    check("reset_rd_error", 32'(rd_error), 32'd0);

    // All bits fire while unlocked: ERROR_POST_LOCK defaults ignore them
    pulse(11'h7FF);
    check("unlocked_error_irq", 32'(error_irq), 32'd0);
    check("unlocked_warning_irq", 32'(warning_irq), 32'd0);
    do_read(11'h000, 11'h000, 1'b0);

    // Holdoff of 5: locked rises in cycle 0, qualifies in cycle 6
    holdoff = HW'(5);
    locked  = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      violations = (k == 4 || k == 7) ? 11'h008 : 11'h000;
      if (k <= 6) check($sformatf("holdoff_qualified_c%0d", k), 32'(qualified), 32'(k == 6));
    end
    check("post_lock_error_irq", 32'(error_irq), 32'd1);
    do_read(11'h008, 11'h000, 1'b0);
    check("after_read_error_irq", 32'(error_irq), 32'd0);

    // Warning class on bit 0
    cfg_write(4'd0, 2'd1);
    pulse(11'h001);
    check("warn_irq_set", 32'(warning_irq), 32'd1);
    do_read(11'h000, 11'h001, 1'b0);
    check("warn_irq_cleared", 32'(warning_irq), 32'd0);

    // Read coincident with bit 9, then a back-to-back read sees nothing new
    violations = 11'h200;
    rd_req = 1'b1;
    push_exp(11'h200, 11'h000, 1'b0);
    tick();
    violations = '0;
    push_exp(11'h000, 11'h000, 1'b0);
    tick();
    rd_req = 1'b0;
    tick();

    // Out-of-range writes dropped; class change after latching keeps status
    cfg_write(4'd11, 2'd0);
    cfg_write(4'd15, 2'd0);
    pulse(11'h7FF);
    cfg_write(4'd5, 2'd0);
    do_read(11'h7FE, 11'h001, 1'b0);
    tick(); tick();
    check("rd_error_held", 32'(rd_error), 32'h7FE);
    check("rd_warning_held", 32'(rd_warning), 32'h001);
    pulse(11'h020);
    do_read(11'h000, 11'h000, 1'b0);

    // Losing a qualified lock
    locked = 1'b0;
    tick();
    check("lock_drop_qualified", 32'(qualified), 32'd0);
    check("lock_lost_error_irq", 32'(error_irq), 32'd1);
    do_read(11'h000, 11'h000, 1'b1);
    check("lock_lost_irq_cleared", 32'(error_irq), 32'd0);

    // Dropping during holdoff is not a lost lock
    holdoff = HW'(5);
    locked  = 1'b1;
    repeat (3) tick();
    locked = 1'b0;
    tick(); tick();
    check("holdoff_drop_error_irq", 32'(error_irq), 32'd0);
    do_read(11'h000, 11'h000, 1'b0);

    // Zero holdoff qualifies on the very next cycle
    holdoff = '0;
    locked  = 1'b1;
    tick();
    check("zero_holdoff_qualified", 32'(qualified), 32'd1);

    // Soft clear: status, irqs, FSM and classes return to reset values
    cfg_write(4'd0, 2'd1);
    cfg_write(4'd1, 2'd2);
    pulse(11'h003);
    check("pre_clear_error_irq", 32'(error_irq), 32'd1);
    check("pre_clear_warning_irq", 32'(warning_irq), 32'd1);
    locked = 1'b0;
    clear_state = 1'b1;
    tick();
    clear_state = 1'b0;
    check("clear_error_irq", 32'(error_irq), 32'd0);
    check("clear_warning_irq", 32'(warning_irq), 32'd0);
    pulse(11'h003);
    do_read(11'h000, 11'h000, 1'b0);

    // Reset asserted in the request cycle suppresses the strobe
    pulse(11'h000);
    rd_req = 1'b1;
    srst   = 1'b1;
    tick();
    rd_req = 1'b0;
    srst   = 1'b0;
    check("reset_mid_read_rd_valid", 32'(rd_valid), 32'd0);
    tick();
    check("reset_mid_read_rd_valid_late", 32'(rd_valid), 32'd0);

`ifdef VIOLATION_CTRL_FIRST_CAPTURE_EN
    cfg_write(4'd1, 2'd2);
    cfg_write(4'd2, 2'd2);
    cfg_write(4'd7, 2'd2);
    pulse(11'h084);
    pulse(11'h002);
    rd_req = 1'b1;
    push_exp(11'h086, 11'h000, 1'b0);
    tick();
    rd_req = 1'b0;
    check("first_valid", 32'(first_valid), 32'd1);
    check("first_idx", 32'(first_idx), 32'd2);
    tick();
`endif

    repeat (3) tick();
    check("reads_outstanding", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
